// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with runtime baud divisor, TX/RX FIFOs, optional parity, sticky errors and a level irq.
// Reads are combinational and DATA reads pop on the same edge; a TX push while full is dropped, and an RX overflow drops the byte and sets rx_ovf.

module uart_mmio_fifo_q #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [7:0]    i_dat,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic [AW:0]   o_count
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_empty, w_push_ok, w_pop_ok;

  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_pop_ok  = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + AW'(1);
      if (w_pop_ok)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= i_dat;
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

module uart_mmio_fifo #(
  parameter int FIFO_AW     = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 651
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_st_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAITH} rx_st_t;

  localparam int CW = FIFO_AW + 1;

  logic [6:0]       r_ctrl;
  logic [DIV_W-1:0] r_div;
  logic [CW-1:0]    r_rxthr;
  logic             r_ovf, r_ferr, r_perr, r_irq;

  logic w_sel_data, w_sel_stat, w_sel_ctrl, w_sel_div, w_sel_thr;
  assign w_sel_data = (addr[4:2] == 3'd0);
  assign w_sel_stat = (addr[4:2] == 3'd1);
  assign w_sel_ctrl = (addr[4:2] == 3'd2);
  assign w_sel_div  = (addr[4:2] == 3'd3);
  assign w_sel_thr  = (addr[4:2] == 3'd4);

  logic w_unused;
  assign w_unused = ^{wdata, addr[1:0]};

  logic [DIV_W-1:0] w_reload;
  assign w_reload = (r_div == '0) ? '0 : r_div - DIV_W'(1);

  // FIFOs
  logic [7:0]    w_tx_head, w_rx_head;
  logic [CW-1:0] w_tx_cnt, w_rx_cnt;
  logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic          w_tx_start, w_rx_pop, w_rx_good;
  logic [7:0]    r_rx_sh;

  uart_mmio_fifo_q #(.AW(FIFO_AW)) u_txq (
    .clk(clk), .reset(reset), .i_push(wr & w_sel_data), .i_dat(wdata[7:0]),
    .i_pop(w_tx_start), .o_head(w_tx_head), .o_count(w_tx_cnt)
  );
  uart_mmio_fifo_q #(.AW(FIFO_AW)) u_rxq (
    .clk(clk), .reset(reset), .i_push(w_rx_good), .i_dat(r_rx_sh),
    .i_pop(w_rx_pop), .o_head(w_rx_head), .o_count(w_rx_cnt)
  );

  assign w_tx_empty = (w_tx_cnt == '0);
  assign w_tx_full  = (w_tx_cnt == CW'(1 << FIFO_AW));
  assign w_rx_empty = (w_rx_cnt == '0);
  assign w_rx_full  = (w_rx_cnt == CW'(1 << FIFO_AW));
  assign w_rx_pop   = rd & w_sel_data & ~w_rx_empty;

  // Transmitter
  tx_st_t           r_tx_st, w_tx_nxt;
  logic [DIV_W-1:0] r_tx_bcnt;
  logic [3:0]       r_tx_tcnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_sh;
  logic             r_tx, r_tx_par, r_tx_pen;
  logic             w_tx_tick, w_tx_bend, w_tx_idle;

  assign w_tx_tick = (r_tx_bcnt == '0);
  assign w_tx_bend = w_tx_tick && (r_tx_tcnt == 4'd15);
  assign w_tx_idle = (r_tx_st == TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_tx_st <= TX_IDLE;
    else       r_tx_st <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt   = r_tx_st;
    w_tx_start = 1'b0;
    case (r_tx_st)
      TX_IDLE:  if (r_ctrl[0] && !w_tx_empty) begin
                  w_tx_nxt   = TX_WAIT;
                  w_tx_start = 1'b1;
                end
      TX_WAIT:  if (w_tx_tick) w_tx_nxt = TX_START;
      TX_START: if (w_tx_bend) w_tx_nxt = TX_DATA;
      TX_DATA:  if (w_tx_bend && r_tx_bit == 3'd7) w_tx_nxt = r_tx_pen ? TX_PAR : TX_STOP;
      TX_PAR:   if (w_tx_bend) w_tx_nxt = TX_STOP;
      TX_STOP:  if (w_tx_bend) w_tx_nxt = TX_IDLE;
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_bcnt <= '0;
      r_tx      <= 1'b1;
      r_tx_sh   <= '0;
      r_tx_tcnt <= '0;
      r_tx_bit  <= '0;
      r_tx_par  <= 1'b0;
      r_tx_pen  <= 1'b0;
    end else begin
      r_tx_bcnt <= w_tx_tick ? w_reload : r_tx_bcnt - DIV_W'(1);
      if (w_tx_start) begin
        r_tx_sh  <= w_tx_head;
        r_tx_par <= (^w_tx_head) ^ r_ctrl[3];
        r_tx_pen <= r_ctrl[2];
      end
      if (w_tx_tick) r_tx_tcnt <= (r_tx_st == TX_WAIT) ? 4'd0 : r_tx_tcnt + 4'd1;
      if (r_tx_st == TX_WAIT && w_tx_tick) r_tx <= 1'b0;
      if (w_tx_bend) begin
        case (r_tx_st)
          TX_START: begin
            r_tx     <= r_tx_sh[0];
            r_tx_bit <= 3'd0;
          end
          TX_DATA: begin
            if (r_tx_bit == 3'd7) begin
              r_tx <= r_tx_pen ? r_tx_par : 1'b1;
            end else begin
              r_tx     <= r_tx_sh[1];
              r_tx_sh  <= r_tx_sh >> 1;
              r_tx_bit <= r_tx_bit + 3'd1;
            end
          end
          TX_PAR, TX_STOP: r_tx <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Receiver
  rx_st_t           r_rx_st, w_rx_nxt;
  logic [DIV_W-1:0] r_rx_bcnt;
  logic [3:0]       r_rx_tcnt;
  logic [2:0]       r_rx_bit;
  logic             r_rx_s1, r_rx_s2, r_rx_pbit;
  logic             w_rx_tick, w_rx_mid, w_rx_bend, w_rx_restart, w_rx_done;
  logic             w_par_bad, w_ferr_set, w_perr_set, w_ovf_set;

  assign w_rx_tick = (r_rx_bcnt == '0);
  assign w_rx_mid  = w_rx_tick && (r_rx_tcnt == 4'd7);
  assign w_rx_bend = w_rx_tick && (r_rx_tcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) r_rx_st <= RX_IDLE;
    else       r_rx_st <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt     = r_rx_st;
    w_rx_restart = 1'b0;
    w_rx_done    = 1'b0;
    if (!r_ctrl[1]) begin
      w_rx_nxt = RX_IDLE;
    end else begin
      case (r_rx_st)
        RX_IDLE:  if (!r_rx_s2) begin
                    w_rx_nxt     = RX_START;
                    w_rx_restart = 1'b1;
                  end
        RX_START: if (w_rx_mid) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (w_rx_bend && r_rx_bit == 3'd7) w_rx_nxt = r_ctrl[2] ? RX_PAR : RX_STOP;
        RX_PAR:   if (w_rx_bend) w_rx_nxt = RX_STOP;
        RX_STOP:  if (w_rx_bend) begin
                    w_rx_done = 1'b1;
                    w_rx_nxt  = r_rx_s2 ? RX_IDLE : RX_WAITH;
                  end
        RX_WAITH: if (r_rx_s2) w_rx_nxt = RX_IDLE;
        default:  w_rx_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_bcnt <= '0;
      r_rx_tcnt <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_pbit <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      if (w_rx_restart || w_rx_tick) r_rx_bcnt <= w_reload;
      else                           r_rx_bcnt <= r_rx_bcnt - DIV_W'(1);
      // After the mid-start sample the tick count realigns so later samples land mid-bit.
      if (w_rx_restart) begin
        r_rx_tcnt <= 4'd0;
        r_rx_bit  <= 3'd0;
      end else if (w_rx_tick) begin
        r_rx_tcnt <= (r_rx_st == RX_START && r_rx_tcnt == 4'd7) ? 4'd0 : r_rx_tcnt + 4'd1;
      end
      if (r_rx_st == RX_DATA && w_rx_bend) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
      if (r_rx_st == RX_PAR && w_rx_bend) r_rx_pbit <= r_rx_s2;
    end
  end

  assign w_par_bad  = r_ctrl[2] && (r_rx_pbit != ((^r_rx_sh) ^ r_ctrl[3]));
  assign w_rx_good  = w_rx_done && r_rx_s2 && !w_par_bad;
  assign w_ferr_set = w_rx_done && !r_rx_s2;
  assign w_perr_set = w_rx_done && r_rx_s2 && w_par_bad;
  assign w_ovf_set  = w_rx_good && w_rx_full && !w_rx_pop;

  // Registers and irq; a new error event wins over a same-cycle clear.
  logic [CW-1:0] w_thr;
  assign w_thr = (r_rxthr == '0) ? CW'(1) : r_rxthr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl  <= 7'h03;
      r_div   <= DIV_W'(DEFAULT_DIV);
      r_rxthr <= CW'(1);
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (wr && w_sel_ctrl) r_ctrl  <= wdata[6:0];
      if (wr && w_sel_div)  r_div   <= wdata[DIV_W-1:0];
      if (wr && w_sel_thr)  r_rxthr <= wdata[CW-1:0];
      if (wr && w_sel_stat && wdata[5]) r_ovf  <= 1'b0;
      if (wr && w_sel_stat && wdata[6]) r_ferr <= 1'b0;
      if (wr && w_sel_stat && wdata[7]) r_perr <= 1'b0;
      if (w_ovf_set)  r_ovf  <= 1'b1;
      if (w_ferr_set) r_ferr <= 1'b1;
      if (w_perr_set) r_perr <= 1'b1;
      r_irq <= (r_ctrl[4] && (w_rx_cnt >= w_thr))
             | (r_ctrl[5] && w_tx_empty && w_tx_idle)
             | (r_ctrl[6] && (r_ovf | r_ferr | r_perr));
    end
  end

  logic [31:0] w_status;
  always_comb begin
    w_status               = '0;
    w_status[0]            = ~w_rx_empty;
    w_status[1]            = w_rx_full;
    w_status[2]            = w_tx_empty;
    w_status[3]            = w_tx_full;
    w_status[4]            = w_tx_idle;
    w_status[5]            = r_ovf;
    w_status[6]            = r_ferr;
    w_status[7]            = r_perr;
    w_status[8 +: CW]      = w_rx_cnt;
    w_status[16 +: CW]     = w_tx_cnt;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr[4:2])
        3'd0:    rdata = {24'b0, (w_rx_empty ? 8'h00 : w_rx_head)};
        3'd1:    rdata = w_status;
        3'd2:    rdata = {25'b0, r_ctrl};
        3'd3:    rdata = 32'(r_div);
        3'd4:    rdata = 32'(r_rxthr);
        default: rdata = '0;
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register map, TX framing, loopback, parity, overflow, glitch/frame errors, irq, reset.
module tb_uart_mmio_fifo;
  localparam logic [4:0] A_DATA = 5'h00, A_STAT = 5'h04, A_CTRL = 5'h08, A_DIV = 5'h0C, A_THR = 5'h10;

  logic        clk = 1'b0;
  logic        reset, rd, wr, tx, irq, lb, rx_drv, rx_w;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata, rv;
  int          checks, errors;

  assign rx_w = lb ? tx : rx_drv;

  uart_mmio_fifo dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rx(rx_w), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk); rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk); rd = 1'b0; addr = '0;
  endtask

  // Expects tx to fall within a few clocks, then samples each bit mid-period (DIV=1).
  task automatic tx_frame(input string tag, input logic [10:0] bits, input int n);
    int lat = 0;
    while (tx !== 1'b0 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'((lat >= 1) && (lat <= 3)), 32'd1);
    if (tx === 1'b0) begin
      repeat (8) @(negedge clk);
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s_b%0d", tag, k), 32'(tx), 32'(bits[k]));
        repeat (16) @(negedge clk);
      end
    end
  endtask

  // Drives one rx frame at DIV=1; call at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic pen, input logic pbit, input logic stop);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    if (pen) begin
      rx_drv = pbit;
      repeat (16) @(negedge clk);
    end
    rx_drv = stop;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; rx_drv = 1'b1; lb = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    bus_rd(A_STAT, rv); chk("rst_status", rv, 32'h14);
    bus_rd(A_CTRL, rv); chk("rst_ctrl", rv, 32'h03);
    bus_rd(A_DIV, rv);  chk("rst_div", rv, 32'd651);
    bus_rd(A_THR, rv);  chk("rst_thr", rv, 32'd1);
    bus_rd(A_DATA, rv); chk("rst_data_empty", rv, 32'h0);
    @(negedge clk); addr = A_STAT; #1 chk("rd_low_zero", rdata, 32'h0);
    bus_rd(5'h14, rv);  chk("unmapped_rd", rv, 32'h0);

    // TX framing at DIV=1; wait out the reset-time reload of 651
    bus_wr(A_DIV, 32'd1);
    repeat (700) @(negedge clk);
    bus_wr(A_DATA, 32'hA5);
    tx_frame("a5", {1'b0, 1'b1, 8'hA5, 1'b0}, 10);
    bus_rd(A_STAT, rv); chk("a5_idle_status", rv, 32'h14);

    // Loopback of three bytes
    lb = 1'b1;
    bus_wr(A_DATA, 32'h00);
    bus_wr(A_DATA, 32'hFF);
    bus_wr(A_DATA, 32'h3C);
    repeat (560) @(negedge clk);
    bus_rd(A_STAT, rv); chk("lb_cnt3", rv, 32'h0315);
    bus_rd(A_DATA, rv); chk("lb_rd0", rv, 32'h00);
    bus_rd(A_STAT, rv); chk("lb_cnt2", rv, 32'h0215);
    bus_rd(A_DATA, rv); chk("lb_rd1", rv, 32'hFF);
    bus_rd(A_STAT, rv); chk("lb_cnt1", rv, 32'h0115);
    bus_rd(A_DATA, rv); chk("lb_rd2", rv, 32'h3C);
    bus_rd(A_STAT, rv); chk("lb_cnt0", rv, 32'h0014);
    bus_rd(A_DATA, rv); chk("lb_rd_empty", rv, 32'h0);
    bus_rd(A_STAT, rv); chk("lb_cnt0_again", rv, 32'h0014);
    lb = 1'b0;

    // Even parity: 0x07 has odd weight so the parity bit is 1
    bus_wr(A_CTRL, 32'h07);
    bus_wr(A_DATA, 32'h07);
    tx_frame("par", {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(A_STAT, rv); chk("perr_set", rv, 32'h94);
    bus_wr(A_STAT, 32'h80);
    bus_rd(A_STAT, rv); chk("perr_clr", rv, 32'h14);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(A_DATA, rv); chk("par_good_rd", rv, 32'h07);

    // Overflow: 17 frames into a 16-deep FIFO
    bus_wr(A_CTRL, 32'h03);
    for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(A_STAT, rv); chk("ovf_status", rv, 32'h1037);
    for (int i = 0; i < 16; i++) begin
      bus_rd(A_DATA, rv);
      chk($sformatf("ovf_rd%0d", i), rv, 32'h10 + 32'(i));
    end
    bus_rd(A_STAT, rv); chk("ovf_after", rv, 32'h34);
    bus_wr(A_STAT, 32'h20);
    bus_rd(A_STAT, rv); chk("ovf_clr", rv, 32'h14);

    // Start-bit glitch, then framing error, then recovery
    @(negedge clk); rx_drv = 1'b0;
    repeat (4) @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    bus_rd(A_STAT, rv); chk("glitch_none", rv, 32'h14);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    bus_rd(A_STAT, rv); chk("ferr_set", rv, 32'h54);
    bus_wr(A_STAT, 32'h40);
    bus_rd(A_STAT, rv); chk("ferr_clr", rv, 32'h14);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(A_DATA, rv); chk("after_ferr_rd", rv, 32'h81);

    // RX threshold irq
    bus_wr(A_THR, 32'd2);
    bus_wr(A_CTRL, 32'h13);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("irq_one_byte", 32'(irq), 32'd0);
    @(negedge clk);
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      begin
        repeat (155) @(negedge clk);
        chk("irq_at_push", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_after_push", 32'(irq), 32'd1);
      end
    join
    bus_rd(A_DATA, rv); chk("irq_rd", rv, 32'h11);
    chk("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_drop", 32'(irq), 32'd0);

    // Reset in the middle of a TX frame
    bus_wr(A_CTRL, 32'h03);
    bus_wr(A_DATA, 32'h00);
    bus_wr(A_DATA, 32'h55);
    repeat (40) @(negedge clk);
    chk("mid_tx_low", 32'(tx), 32'd0);
    bus_rd(A_STAT, rv); chk("mid_status", rv, 32'h0001_0101);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    rd = 1'b1; addr = A_STAT;
    #1 chk("rst_mid_status", rdata, 32'h14);
    @(negedge clk);
    rd = 1'b0; addr = '0; reset = 1'b0;
    bus_rd(A_CTRL, rv); chk("rst_mid_ctrl", rv, 32'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
